// File: rtl/exhaustive_response_checker.sv
// Sweeps every input pattern of a small combinational DUT, compares each response
// against a writable golden table and compacts the sampled responses into a MISR.
module exhaustive_response_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            i_ck,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_golden_we,
  input  logic [N_IN-1:0] i_golden_addr,
  input  logic            i_golden_bit,
  input  logic            i_dut_out,
  output logic [N_IN-1:0] o_pattern,
  output logic            o_busy,
  output logic            o_done,
  output logic [N_IN:0]   o_mismatch_count,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_first_fail,
  output logic [15:0]     o_signature
);

  localparam int              N_PAT       = 1 << N_IN;
  localparam logic [1:0]      S_IDLE      = 2'd0;
  localparam logic [1:0]      S_WAIT      = 2'd1;
  localparam logic [1:0]      S_SAMPLE    = 2'd2;
  localparam logic [1:0]      S_DONE      = 2'd3;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_PAT    = '1;
  localparam logic [N_IN:0]   MC_MAX      = (N_IN + 1)'(N_PAT);

  logic [1:0]       r_state;
  logic [3:0]       r_settle_cnt;
  logic [N_IN-1:0]  r_pattern;
  logic [N_IN:0]    r_mismatch_count;
  logic             r_fail_valid;
  logic [N_IN-1:0]  r_first_fail;
  logic [15:0]      r_signature;
  logic [N_PAT-1:0] r_golden;

  logic        w_idle_or_done;
  logic        w_accept_start;
  logic        w_mismatch;
  logic [15:0] w_sig_next;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept_start = w_idle_or_done && i_start;
  assign w_mismatch     = (i_dut_out != r_golden[r_pattern]);
  assign w_sig_next     = {r_signature[14:0], 1'b0}
                        ^ (r_signature[15] ? 16'h1021 : 16'h0000)
                        ^ {15'b0, i_dut_out};

  // Golden writes are only accepted outside a sweep, so a write alongside start still lands.
  always_ff @(posedge i_ck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_golden <= '0;
    end else if (i_golden_we && w_idle_or_done) begin
      r_golden[i_golden_addr] <= i_golden_bit;
    end
  end

  always_ff @(posedge i_ck or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= S_IDLE;
      r_settle_cnt     <= '0;
      r_pattern        <= '0;
      r_mismatch_count <= '0;
      r_fail_valid     <= 1'b0;
      r_first_fail     <= '0;
      r_signature      <= 16'hFFFF;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept_start) begin
            r_state          <= S_WAIT;
            r_settle_cnt     <= '0;
            r_pattern        <= '0;
            r_mismatch_count <= '0;
            r_fail_valid     <= 1'b0;
            r_first_fail     <= '0;
            r_signature      <= 16'hFFFF;
          end
        end
        S_WAIT: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_signature <= w_sig_next;
          if (w_mismatch) begin
            if (r_mismatch_count != MC_MAX) begin
              r_mismatch_count <= r_mismatch_count + 1'b1;
            end
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_first_fail <= r_pattern;
            end
          end
          if (r_pattern == LAST_PAT) begin
            r_state <= S_DONE;
          end else begin
            r_pattern    <= r_pattern + 1'b1;
            r_settle_cnt <= '0;
            r_state      <= S_WAIT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_pattern        = r_pattern;
  assign o_busy           = (r_state == S_WAIT) || (r_state == S_SAMPLE);
  assign o_done           = (r_state == S_DONE);
  assign o_mismatch_count = r_mismatch_count;
  assign o_fail_valid     = r_fail_valid;
  assign o_first_fail     = r_first_fail;
  assign o_signature      = r_signature;

endmodule

// File: tb/tb_exhaustive_response_checker.sv
// Directed bench for exhaustive_response_checker (N_IN=3, SETTLE=1).
module tb_exhaustive_response_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       golden_we = 1'b0;
  logic [2:0] golden_addr = 3'd0;
  logic       golden_bit = 1'b0;
  logic       dut_out;
  logic [2:0] pattern;
  logic       busy;
  logic       done;
  logic [3:0] mismatch_count;
  logic       fail_valid;
  logic [2:0] first_fail;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  exhaustive_response_checker #(.N_IN(3), .SETTLE(1)) dut (
    .i_ck             (clk),
    .i_reset_n        (reset_n),
    .i_start          (start),
    .i_golden_we      (golden_we),
    .i_golden_addr    (golden_addr),
    .i_golden_bit     (golden_bit),
    .i_dut_out        (dut_out),
    .o_pattern        (pattern),
    .o_busy           (busy),
    .o_done           (done),
    .o_mismatch_count (mismatch_count),
    .o_fail_valid     (fail_valid),
    .o_first_fail     (first_fail),
    .o_signature      (signature)
  );

  always #5 clk = ~clk;

  // Modelled DUT: 0 tie-low, 1 tie-high, 2 parity, 3 parity with a fault at index 5.
  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0: dut_out = 1'b0;
      1: dut_out = 1'b1;
      2: dut_out = ^pattern;
      default: dut_out = (^pattern) ^ (pattern == 3'd5);
    endcase
  end

  function automatic logic [15:0] sig_sweep(input logic [7:0] bits);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, bits[i]};
    end
    return s;
  endfunction

  task automatic write_golden(input logic [2:0] a, input logic b);
    golden_addr = a;
    golden_bit  = b;
    golden_we   = 1'b1;
    @(posedge clk);
    #1 golden_we = 1'b0;
  endtask

  task automatic load_golden(input logic [7:0] tbl);
    for (int i = 0; i < 8; i++) write_golden(3'(i), tbl[i]);
  endtask

  task automatic run_sweep(output int cycles);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pattern !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: pattern=%0d busy=%b done=%b, required 0/0/0", pattern, busy, done);
    end
    checks++;
    if (mismatch_count !== 4'd0 || fail_valid !== 1'b0 || first_fail !== 3'd0 || signature !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_results: mc=%0d fv=%b ff=%0d sig=%h, required 0/0/0/ffff",
               mismatch_count, fail_valid, first_fail, signature);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0/0", busy, done);
    end
  endtask

  task automatic test_all_zero();
    mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      checks++;
      if (pattern !== 3'(j / 2) || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_step%0d: pattern=%0d busy=%b done=%b, required %0d/1/0",
                 j, pattern, busy, done, j / 2);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pattern !== 3'd7) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b pattern=%0d, required 1/0/7", done, busy, pattern);
    end
    checks++;
    if (mismatch_count !== 4'd0 || fail_valid !== 1'b0 || signature !== sig_sweep(8'h00)) begin
      errors++;
      $display("FAIL zero_results: mc=%0d fv=%b sig=%h, required 0/0/%h",
               mismatch_count, fail_valid, signature, sig_sweep(8'h00));
    end
  endtask

  task automatic test_parity();
    int cyc;
    load_golden(8'b1001_0110);
    mode = 2;
    run_sweep(cyc);
    checks++;
    if (cyc !== 16 || mismatch_count !== 4'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL parity_clean: cycles=%0d mc=%0d fv=%b, required 16/0/0", cyc, mismatch_count, fail_valid);
    end
    checks++;
    if (signature !== sig_sweep(8'b1001_0110)) begin
      errors++;
      $display("FAIL parity_sig: sig=%h, required %h", signature, sig_sweep(8'b1001_0110));
    end
    mode = 3;
    run_sweep(cyc);
    checks++;
    if (cyc !== 16 || mismatch_count !== 4'd1 || fail_valid !== 1'b1 || first_fail !== 3'b101) begin
      errors++;
      $display("FAIL parity_fault: cycles=%0d mc=%0d fv=%b ff=%0d, required 16/1/1/5",
               cyc, mismatch_count, fail_valid, first_fail);
    end
    checks++;
    if (signature !== sig_sweep(8'b1011_0110)) begin
      errors++;
      $display("FAIL parity_fault_sig: sig=%h, required %h", signature, sig_sweep(8'b1011_0110));
    end
  endtask

  task automatic test_all_ones();
    int cyc;
    load_golden(8'h00);
    mode = 1;
    run_sweep(cyc);
    checks++;
    if (cyc !== 16 || mismatch_count !== 4'b1000 || fail_valid !== 1'b1 || first_fail !== 3'd0) begin
      errors++;
      $display("FAIL ones_results: cycles=%0d mc=%0d fv=%b ff=%0d, required 16/8/1/0",
               cyc, mismatch_count, fail_valid, first_fail);
    end
    checks++;
    if (signature !== sig_sweep(8'hFF)) begin
      errors++;
      $display("FAIL ones_sig: sig=%h, required %h", signature, sig_sweep(8'hFF));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || mismatch_count !== 4'b1000 || signature !== sig_sweep(8'hFF)) begin
      errors++;
      $display("FAIL ones_hold: done=%b mc=%0d sig=%h, required 1/8/%h",
               done, mismatch_count, signature, sig_sweep(8'hFF));
    end
  endtask

  task automatic test_back_to_back();
    mode = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++;
    if (mismatch_count !== 4'd0 || fail_valid !== 1'b0 || signature !== 16'hFFFF ||
        done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: mc=%0d fv=%b sig=%h done=%b busy=%b, required 0/0/ffff/0/1",
               mismatch_count, fail_valid, signature, done, busy);
    end
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk);
      #1;
      start       = (j % 3 == 0);
      golden_we   = (j == 5 || j == 9);
      golden_addr = 3'd2;
      golden_bit  = 1'b1;
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    golden_we = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_early: done=%b busy=%b at cycle 15, required 0/1", done, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_schedule: done=%b busy=%b at cycle 16, required 1/0", done, busy);
    end
    checks++;
    if (mismatch_count !== 4'd0 || fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_golden_write: mc=%0d fv=%b, required 0/0", mismatch_count, fail_valid);
    end
  endtask

  task automatic test_start_with_write();
    int cyc;
    mode = 0;
    golden_addr = 3'd0;
    golden_bit  = 1'b1;
    golden_we   = 1'b1;
    start       = 1'b1;
    @(posedge clk);
    #1;
    golden_we = 1'b0;
    start     = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (cyc !== 16 || mismatch_count !== 4'd1 || fail_valid !== 1'b1 || first_fail !== 3'd0) begin
      errors++;
      $display("FAIL start_with_write: cycles=%0d mc=%0d fv=%b ff=%0d, required 16/1/1/0",
               cyc, mismatch_count, fail_valid, first_fail);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    load_golden(8'b1001_0110);
    mode = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (pattern !== 3'd3 && cyc < 40);
    checks++;
    if (pattern !== 3'd3 || fail_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_reach: pattern=%0d fv=%b, required 3/1", pattern, fail_valid);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pattern !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || mismatch_count !== 4'd0 ||
        fail_valid !== 1'b0 || first_fail !== 3'd0 || signature !== 16'hFFFF) begin
      errors++;
      $display("FAIL midreset_async: pat=%0d busy=%b done=%b mc=%0d fv=%b ff=%0d sig=%h, required all reset",
               pattern, busy, done, mismatch_count, fail_valid, first_fail, signature);
    end
    #2 reset_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || pattern !== 3'd0) begin
        errors++;
        $display("FAIL midreset_idle%0d: busy=%b pattern=%0d, required 0/0", j, busy, pattern);
      end
    end
    run_sweep(cyc);
    checks++;
    if (cyc !== 16 || mismatch_count !== 4'd8) begin
      errors++;
      $display("FAIL midreset_golden_cleared: cycles=%0d mc=%0d, required 16/8", cyc, mismatch_count);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_parity();
    test_all_ones();
    test_back_to_back();
    test_start_with_write();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
